mult_booth_seq: RTL and testbench

MULT_BOOTH_SEQ -- requirements
Module: mult_booth_seq

---
 rtl/mult_booth_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_mult_booth_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_booth_seq.sv
// rtl/mult_booth_seq.sv - radix-2 Booth sequential 32x32 signed multiplier
// Iterates one Booth step per cycle through a two-level carry-lookahead adder.

module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_pg,
  output logic       o_gg
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:1] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ {w_c, i_cin};
  assign o_pg  = &w_p;
  assign o_gg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module lcu4 (
  input  logic [3:0] i_p,
  input  logic [3:0] i_g,
  input  logic       i_cin,
  output logic [3:1] o_c,
  output logic       o_pg,
  output logic       o_gg
);
  assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_cin);
  assign o_pg   = &i_p;
  assign o_gg   = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
endmodule

module cla32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [7:0] w_pg;
  logic [7:0] w_gg;
  logic [7:0] w_gc;
  logic [3:1] w_c_lo;
  logic [3:1] w_c_hi;
  logic       w_c16;
  logic       w_pg_lo;
  logic       w_gg_lo;
  logic       w_pg_hi;
  logic       w_gg_hi;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      cla4 u_grp (
        .i_a   (i_a[4*gi +: 4]),
        .i_b   (i_b[4*gi +: 4]),
        .i_cin (w_gc[gi]),
        .o_sum (o_sum[4*gi +: 4]),
        .o_pg  (w_pg[gi]),
        .o_gg  (w_gg[gi])
      );
    end
  endgenerate

  lcu4 u_lcu_lo (
    .i_p   (w_pg[3:0]),
    .i_g   (w_gg[3:0]),
    .i_cin (i_cin),
    .o_c   (w_c_lo),
    .o_pg  (w_pg_lo),
    .o_gg  (w_gg_lo)
  );

  assign w_c16 = w_gg_lo | (w_pg_lo & i_cin);

  lcu4 u_lcu_hi (
    .i_p   (w_pg[7:4]),
    .i_g   (w_gg[7:4]),
    .i_cin (w_c16),
    .o_c   (w_c_hi),
    .o_pg  (w_pg_hi),
    .o_gg  (w_gg_hi)
  );

  assign w_gc   = {w_c_hi, w_c16, w_c_lo, i_cin};
  assign o_cout = w_gg_hi | (w_pg_hi & w_c16);
endmodule

module mult_booth_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [32:0] r_a;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [31:0] r_m;
  logic [5:0]  r_cnt;
  logic [31:0] r_prod_hi;
  logic [31:0] r_prod_lo;

  logic [1:0]  w_sel;
  logic        w_sub;
  logic [31:0] w_b;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [32:0] w_a_upd;
  logic [32:0] w_a_shr;
  logic [31:0] w_q_shr;
  logic        w_last;

  assign w_sel = {r_q[0], r_qm1};
  assign w_sub = (w_sel == 2'b10);
  assign w_b   = w_sub ? ~r_m : r_m;

  cla32 u_add (
    .i_a    (r_a[31:0]),
    .i_b    (w_b),
    .i_cin  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Bit 32 is the sign-extended sum, so M = 0x80000000 cannot overflow A.
  always_comb begin
    w_a_upd = r_a;
    if (w_sel == 2'b01 || w_sel == 2'b10) begin
      w_a_upd = {r_a[32] ^ w_b[31] ^ w_cout, w_sum};
    end
  end

  assign w_a_shr = {w_a_upd[32], w_a_upd[32:1]};
  assign w_q_shr = {w_a_upd[0], r_q[31:1]};
  assign w_last  = (r_cnt == 6'd31);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_BUSY : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_m   <= op_a;
            r_q   <= op_b;
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_BUSY: begin
          r_a   <= w_a_shr;
          r_q   <= w_q_shr;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 6'd1;
          if (w_last) begin
            r_prod_hi <= w_a_shr[31:0];
            r_prod_lo <= w_q_shr;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == S_BUSY);
  assign done    = (r_state == S_DONE);
  assign prod_hi = r_prod_hi;
  assign prod_lo = r_prod_lo;
endmodule

// File: tb/tb_mult_booth_seq.sv
// tb/tb_mult_booth_seq.sv - self-checking bench for mult_booth_seq
// Directed cases plus random operands against a plain signed-multiply model.

module tb_mult_booth_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  int checks = 0;
  int failures = 0;

  mult_booth_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
  endtask

  // Counts negedges after the accepting edge; operands are scrambled once accepted.
  task automatic wait_done(input int k0, input int poke, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = k0 + 1; k <= k0 + 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      if (k == 1) begin
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
      end
      if (poke != 0 && k == poke) begin
        start = 1'b1;
        op_a  = 32'd9;
      end
      if (poke != 0 && k == poke + 1) start = 1'b0;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int poke,
                       input logic [63:0] exp, input string tag);
    int lat;
    int bcnt;
    launch(a, b);
    wait_done(0, poke, lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(bcnt), 64'd32);
    chk({tag, "_prod"}, {prod_hi, prod_lo}, exp);
    @(negedge clk);
    chk({tag, "_done1"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int nd;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clk);
    chk("rst_flags", {62'd0, busy, done}, 64'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(32'd3, 32'd5, 0, 64'h0000_0000_0000_000F, "d3x5");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h0000_0000_0000_0001, "dm1sq");
    do_op(32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000, "dminsq");
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 0, 64'hC000_0000_8000_0000, "dmaxmin");
    do_op(32'd6, 32'd7, 10, 64'h0000_0000_0000_002A, "dignore");

    launch(32'hFFFF_FFFC, 32'd3);
    wait_done(0, 0, lat, bcnt);
    chk("b2b1_lat", 64'(lat), 64'd33);
    chk("b2b1_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFF4);
    launch(32'd2, 32'd2);
    @(negedge clk);
    chk("b2b_flags", {62'd0, busy, done}, 64'd2);
    chk("b2b_hold", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFF4);
    start = 1'b0;
    wait_done(1, 0, lat, bcnt);
    chk("b2b2_lat", 64'(lat), 64'd33);
    chk("b2b2_prod", {prod_hi, prod_lo}, 64'd4);
    @(negedge clk);
    chk("b2b2_done1", {62'd0, busy, done}, 64'd0);

    launch(32'd1234, 32'd5678);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_flags", {62'd0, busy, done}, 64'd0);
    chk("rstmid_prod", {prod_hi, prod_lo}, 64'd0);
    rst = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rstmid_nodone", 64'(nd), 64'd0);

    rst = 1'b0;
    launch(32'd5, 32'd5);
    @(negedge clk);
    chk("rst_prio", {62'd0, busy, done}, 64'd0);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_prio_after", {62'd0, busy, done}, 64'd0);

    do_op(32'hFFFF_FFF9, 32'd100, 0, 64'hFFFF_FFFF_FFFF_FD44, "dpost");

    for (int n = 0; n < 12; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n == 3) ra = 32'h8000_0000;
      if (n == 7) rb = 32'h8000_0000;
      do_op(ra, rb, 0, ref_mul(ra, rb), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
